// File: rtl/ahb_lite_reg_slave_if.sv
// AHB-Lite signal bundle between a bus master (or interconnect) and the
// register slave. The master side also drives the bus-level hready.
interface ahb_lite_reg_slave_if;
  logic        hsel;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_lite_reg_slave.sv
// AHB-Lite register slave: sixteen 32-bit registers (0-14 read/write,
// 15 a read-only ID word), WAIT_STATES wait cycles on every OKAY data phase,
// and a two-cycle ERROR response for illegal transfers.
module ahb_lite_reg_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h0A5B_0001
) (
  input logic                 clk,
  input logic                 rst,
  ahb_lite_reg_slave_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  localparam bit         HAS_WAIT  = (WAIT_STATES != 0);
  localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [3:0] ID_INDEX  = 4'd15;

  // Transfer legality: supported size, natural alignment, inside the 64-byte
  // window, and no write to the ID register.
  function automatic logic xfer_legal(input logic [15:0] addr,
                                      input logic [2:0]  size,
                                      input logic        write);
    logic size_ok;
    case (size)
      3'd0:    size_ok = 1'b1;
      3'd1:    size_ok = (addr[0] == 1'b0);
      3'd2:    size_ok = (addr[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
    return size_ok && (addr[15:6] == 10'd0) && !(write && (addr[5:2] == ID_INDEX));
  endfunction

  // Byte lanes touched by a legal transfer of the given size and offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] offs,
                                           input logic [2:0] size);
    logic [3:0] mask;
    case (size)
      3'd0:    mask = 4'b0001 << offs;
      3'd1:    mask = offs[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_nxt_s;
  logic        pend_r;       // a legal data phase is outstanding
  logic        pend_nxt_s;
  logic        write_r;
  logic [3:0]  idx_r;
  logic [3:0]  be_r;
  logic        hreadyout_r;
  logic        hresp_r;
  logic        ready_nxt_s;
  logic        resp_nxt_s;
  logic        load_s;
  logic        take_s;
  logic        legal_s;
  logic        complete_s;
  logic        commit_s;
  logic [31:0] rdata_s;
  logic [31:0] rf_r [0:14];
  logic        unused_s;

  // A new address phase only reaches the FSM in states that present ready.
  assign take_s     = bus.hsel && bus.hready && bus.htrans[1];
  assign legal_s    = xfer_legal(bus.haddr, bus.hsize, bus.hwrite);
  assign complete_s = (state_r == ST_IDLE) && pend_r;
  assign commit_s   = complete_s && write_r && (idx_r != ID_INDEX);
  assign unused_s   = ^{bus.hprot, bus.htrans[0]};

  assign bus.hreadyout = hreadyout_r;
  assign bus.hresp     = hresp_r;
  assign bus.hrdata    = rdata_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, wait counter, pending flag and next handshake outputs
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pend_nxt_s  = pend_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (take_s && legal_s) begin
          load_s     = 1'b1;
          pend_nxt_s = 1'b1;
          if (HAS_WAIT) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 3'd0;
          end
        end else if (take_s) begin
          state_nxt_s = ST_ERR1;
          pend_nxt_s  = 1'b0;
          cnt_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_IDLE;
          pend_nxt_s  = 1'b0;
          cnt_nxt_s   = 3'd0;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      ST_ERR1: begin
        state_nxt_s = ST_ERR2;
        pend_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pend_nxt_s  = 1'b0;
        cnt_nxt_s   = 3'd0;
      end
    endcase
    ready_nxt_s = !((state_nxt_s == ST_WAIT) || (state_nxt_s == ST_ERR1));
    resp_nxt_s  = (state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2);
  end

  // Counter, latched address phase and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= 3'd0;
      pend_r      <= 1'b0;
      write_r     <= 1'b0;
      idx_r       <= 4'd0;
      be_r        <= 4'd0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      pend_r      <= pend_nxt_s;
      hreadyout_r <= ready_nxt_s;
      hresp_r     <= resp_nxt_s;
      if (load_s) begin
        write_r <= bus.hwrite;
        idx_r   <= bus.haddr[5:2];
        be_r    <= lane_mask(bus.haddr[1:0], bus.hsize);
      end
    end
  end

  // Register file: cleared on reset, byte-lane merge at the end of a write completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        rf_r[i] <= 32'h0;
      end
    end else if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_r[b]) begin
          rf_r[idx_r][8*b +: 8] <= bus.hwdata[8*b +: 8];
        end
      end
    end
  end

  // Read data is driven only in the completion cycle of a read, zero otherwise
  always_comb begin
    rdata_s = 32'h0;
    if (complete_s && !write_r) begin
      if (idx_r == ID_INDEX) begin
        rdata_s = ID_VALUE;
      end else begin
        rdata_s = rf_r[idx_r];
      end
    end else begin
      rdata_s = 32'h0;
    end
  end

endmodule
